// File: rtl/flag_reg_stack.sv
// Condition-flag register with per-flag write enables and a LIFO save/restore stack.
// Optional sticky overflow/underflow flag built when FLAG_REG_STACK_ERR_EN is defined.
module flag_reg_stack #(
    parameter int FLAG_W      = 3,
    parameter int STACK_DEPTH = 4,
    localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              flag_rst,
    input  logic [FLAG_W-1:0] flag_in,
    input  logic [FLAG_W-1:0] flag_we,
    input  logic              flag_push,
    input  logic              flag_pop,
    output logic [FLAG_W-1:0] flag_out,
    output logic [LVL_W-1:0]  stack_level,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SLOTS = 1 << IDX_W;
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(STACK_DEPTH);

    generate
        if (STACK_DEPTH < 1) begin : g_bad_depth
            $error("flag_reg_stack: STACK_DEPTH must be at least 1");
        end
    endgenerate

    // Slot storage is deliberately not reset; entries above the level are unreachable.
    logic [FLAG_W-1:0] slot [SLOTS];

    logic             push_only;
    logic             pop_only;
    logic             do_push;
    logic             do_pop;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic [FLAG_W-1:0] flag_wr;

    assign stack_empty = (stack_level == '0);
    assign stack_full  = (stack_level == LVL_MAX);

    // Simultaneous push and pop cancel: no stack movement and no error event.
    assign push_only = flag_push & ~flag_pop;
    assign pop_only  = flag_pop & ~flag_push;
    assign do_push   = push_only & ~stack_full;
    assign do_pop    = pop_only & ~stack_empty;

    assign push_idx = IDX_W'(stack_level);
    assign pop_idx  = IDX_W'(stack_level - LVL_ONE);
    assign flag_wr  = (flag_out & ~flag_we) | (flag_in & flag_we);

    always_ff @(posedge clk) begin
        if (do_push) begin
            slot[push_idx] <= flag_out;
        end
    end

    always_ff @(posedge clk or posedge flag_rst) begin
        if (flag_rst) begin
            flag_out    <= '0;
            stack_level <= '0;
        end else begin
            if (do_pop) begin
                flag_out <= slot[pop_idx];
            end else begin
                flag_out <= flag_wr;
            end
            if (do_push) begin
                stack_level <= stack_level + LVL_ONE;
            end else if (do_pop) begin
                stack_level <= stack_level - LVL_ONE;
            end
        end
    end

`ifdef FLAG_REG_STACK_ERR_EN
    logic overflow;
    logic underflow;
    logic err_q;

    assign overflow  = push_only & stack_full;
    assign underflow = pop_only & stack_empty;

    always_ff @(posedge clk or posedge flag_rst) begin
        if (flag_rst) begin
            err_q <= 1'b0;
        end else if (overflow | underflow) begin
            err_q <= 1'b1;
        end
    end

    assign stack_err = err_q;
`else
    assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_flag_reg_stack.sv
// Directed self-checking bench for flag_reg_stack at default parameters.
module tb_flag_reg_stack;

`ifdef FLAG_REG_STACK_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       flag_rst;
    logic [2:0] flag_in;
    logic [2:0] flag_we;
    logic       flag_push;
    logic       flag_pop;
    logic [2:0] flag_out;
    logic [2:0] stack_level;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    int n_vec;
    int n_err;

    flag_reg_stack #(.FLAG_W(3), .STACK_DEPTH(4)) dut (
        .clk        (clk),
        .flag_rst   (flag_rst),
        .flag_in    (flag_in),
        .flag_we    (flag_we),
        .flag_push  (flag_push),
        .flag_pop   (flag_pop),
        .flag_out   (flag_out),
        .stack_level(stack_level),
        .stack_empty(stack_empty),
        .stack_full (stack_full),
        .stack_err  (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] fin, input logic [2:0] fwe,
                         input logic push, input logic pop);
        flag_in   = fin;
        flag_we   = fwe;
        flag_push = push;
        flag_pop  = pop;
    endtask

    task automatic test_reset();
        flag_rst = 1'b1;
        drive(3'b111, 3'b111, 1'b0, 1'b0);
        step();
        step();
        n_vec++;
        if (flag_out !== 3'b000) begin
            n_err++; $display("FAIL rst_out: got %b want 000", flag_out);
        end
        n_vec++;
        if (stack_level !== 3'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0) begin
            n_err++; $display("FAIL rst_stack: level=%0d empty=%b full=%b want 0/1/0",
                              stack_level, stack_empty, stack_full);
        end
        n_vec++;
        if (stack_err !== 1'b0) begin
            n_err++; $display("FAIL rst_err: got %b want 0", stack_err);
        end
        flag_rst = 1'b0;
        step();
        n_vec++;
        if (flag_out !== 3'b111) begin
            n_err++; $display("FAIL rst_release: got %b want 111", flag_out);
        end
    endtask

    task automatic test_per_flag_write();
        drive(3'b000, 3'b111, 1'b0, 1'b0);
        step();
        n_vec++;
        if (flag_out !== 3'b000) begin
            n_err++; $display("FAIL wr_clear: got %b want 000", flag_out);
        end
        drive(3'b111, 3'b001, 1'b0, 1'b0);
        step();
        n_vec++;
        if (flag_out !== 3'b001) begin
            n_err++; $display("FAIL wr_carry: got %b want 001", flag_out);
        end
        drive(3'b111, 3'b100, 1'b0, 1'b0);
        step();
        n_vec++;
        if (flag_out !== 3'b101) begin
            n_err++; $display("FAIL wr_borrow: got %b want 101", flag_out);
        end
    endtask

    task automatic test_push_pop();
        drive(3'b010, 3'b111, 1'b1, 1'b0);
        step();
        n_vec++;
        if (flag_out !== 3'b010 || stack_level !== 3'd1) begin
            n_err++; $display("FAIL rt_push: out=%b level=%0d want 010/1", flag_out, stack_level);
        end
        drive(3'b000, 3'b111, 1'b0, 1'b1);
        step();
        n_vec++;
        if (flag_out !== 3'b101 || stack_level !== 3'd0 || stack_empty !== 1'b1) begin
            n_err++; $display("FAIL rt_pop: out=%b level=%0d empty=%b want 101/0/1",
                              flag_out, stack_level, stack_empty);
        end
    endtask

    task automatic test_fill_overflow();
        drive(3'd1, 3'b111, 1'b0, 1'b0);
        step();
        // each push saves i while loading i+1
        for (int i = 1; i <= 4; i++) begin
            drive(3'(i + 1), 3'b111, 1'b1, 1'b0);
            step();
            n_vec++;
            if (stack_level !== 3'(i) || flag_out !== 3'(i + 1)) begin
                n_err++; $display("FAIL fill_%0d: level=%0d out=%0d want %0d/%0d",
                                  i, stack_level, flag_out, i, i + 1);
            end
        end
        n_vec++;
        if (stack_full !== 1'b1 || stack_empty !== 1'b0) begin
            n_err++; $display("FAIL full_flag: full=%b empty=%b want 1/0", stack_full, stack_empty);
        end
        drive(3'd6, 3'b111, 1'b1, 1'b0);
        step();
        n_vec++;
        if (stack_level !== 3'd4 || flag_out !== 3'd6 || stack_err !== ERR_EN) begin
            n_err++; $display("FAIL overflow: level=%0d out=%0d err=%b want 4/6/%b",
                              stack_level, flag_out, stack_err, ERR_EN);
        end
        for (int i = 4; i >= 1; i--) begin
            drive(3'd0, 3'b000, 1'b0, 1'b1);
            step();
            n_vec++;
            if (flag_out !== 3'(i) || stack_level !== 3'(i - 1)) begin
                n_err++; $display("FAIL unfill_%0d: out=%0d level=%0d want %0d/%0d",
                                  i, flag_out, stack_level, i, i - 1);
            end
        end
    endtask

    task automatic test_underflow();
        drive(3'b010, 3'b010, 1'b0, 1'b1);
        step();
        n_vec++;
        if (flag_out !== 3'b011 || stack_level !== 3'd0 || stack_err !== ERR_EN) begin
            n_err++; $display("FAIL underflow: out=%b level=%0d err=%b want 011/0/%b",
                              flag_out, stack_level, stack_err, ERR_EN);
        end
    endtask

    task automatic test_back_to_back();
        flag_rst = 1'b1;
        #2;
        flag_rst = 1'b0;
        drive(3'b000, 3'b000, 1'b1, 1'b0);
        step();
        step();
        drive(3'b101, 3'b111, 1'b1, 1'b1);
        step();
        n_vec++;
        if (stack_level !== 3'd2 || flag_out !== 3'b101 || stack_err !== 1'b0) begin
            n_err++; $display("FAIL push_pop: level=%0d out=%b err=%b want 2/101/0",
                              stack_level, flag_out, stack_err);
        end
        drive(3'b000, 3'b000, 1'b1, 1'b0);
        step();
        n_vec++;
        if (stack_level !== 3'd3) begin
            n_err++; $display("FAIL level3: got %0d want 3", stack_level);
        end
        drive(3'b000, 3'b000, 1'b0, 1'b1);
        #2;
        flag_rst = 1'b1;
        #1;
        n_vec++;
        if (stack_level !== 3'd0 || stack_err !== 1'b0 || flag_out !== 3'b000 || stack_empty !== 1'b1) begin
            n_err++; $display("FAIL midrst: level=%0d err=%b out=%b empty=%b want 0/0/000/1",
                              stack_level, stack_err, flag_out, stack_empty);
        end
        step();
        flag_rst = 1'b0;
        drive(3'b000, 3'b000, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        flag_rst = 1'b1;
        drive(3'b000, 3'b000, 1'b0, 1'b0);
        test_reset();
        test_per_flag_write();
        test_push_pop();
        test_fill_overflow();
        test_underflow();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
